// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core load/store path and a
// loader/debug master, with bounded starvation in both directions.
module dmem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_c_req,
  input  logic          i_c_we,
  input  logic [AW-1:0] i_c_addr,
  input  logic [DW-1:0] i_c_wdata,
  output logic [DW-1:0] o_c_rdata,
  output logic          o_c_gnt,
  output logic          o_c_stall,
  input  logic          i_l_req,
  input  logic          i_l_we,
  input  logic          i_l_lock,
  input  logic [AW-1:0] i_l_addr,
  input  logic [DW-1:0] i_l_wdata,
  output logic          o_l_gnt,
  output logic          o_l_rvalid,
  output logic [DW-1:0] o_l_rdata,
  output logic          o_m_we,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  input  logic [DW-1:0] i_m_rdata
);

  localparam int SW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [SW-1:0] WAIT_MAX = SW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

  typedef enum logic {S_OPEN = 1'b0, S_LOCK = 1'b1} state_t;

  state_t        r_state, w_state_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  logic [LW-1:0] r_lock, w_lock_nxt;
  logic          r_l_rvalid;
  logic [DW-1:0] r_l_rdata;
  logic          w_c_gnt, w_l_gnt;

  always_comb begin
    w_c_gnt      = 1'b0;
    w_l_gnt      = 1'b0;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_lock_nxt   = r_lock;
    if (i_rst) begin
      // Reset kills any grant in the same cycle, including a mid-burst write.
      w_state_nxt  = S_OPEN;
      w_starve_nxt = '0;
      w_lock_nxt   = '0;
    end else begin
      if (r_state == S_OPEN)
        w_l_gnt = i_l_req & (~i_c_req | (r_starve == WAIT_MAX));
      else
        w_l_gnt = i_l_req & ~(i_c_req & (r_lock == LOCK_MAX));
      w_c_gnt = i_c_req & ~w_l_gnt;

      if (w_l_gnt || !i_l_req)
        w_starve_nxt = '0;
      else if (w_c_gnt && (r_starve != WAIT_MAX))
        w_starve_nxt = r_starve + 1'b1;

      if (r_state == S_OPEN) begin
        if (w_l_gnt && i_l_lock) begin
          w_state_nxt = S_LOCK;
          w_lock_nxt  = LW'(1);
        end
      end else begin
        if (!i_l_req || (w_l_gnt && !i_l_lock)) begin
          w_state_nxt = S_OPEN;
          w_lock_nxt  = '0;
        end else if (w_l_gnt) begin
          if (r_lock != LOCK_MAX) w_lock_nxt = r_lock + 1'b1;
        end else begin
          // Yield cycle: core took the port, lock window restarts.
          w_lock_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_OPEN;
      r_starve   <= '0;
      r_lock     <= '0;
      r_l_rvalid <= 1'b0;
      r_l_rdata  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_starve   <= w_starve_nxt;
      r_lock     <= w_lock_nxt;
      r_l_rvalid <= w_l_gnt & ~i_l_we;
      if (w_l_gnt && !i_l_we) r_l_rdata <= i_m_rdata;
    end
  end

  assign o_c_gnt    = w_c_gnt;
  assign o_l_gnt    = w_l_gnt;
  assign o_c_stall  = i_c_req & ~w_c_gnt & ~i_rst;
  assign o_c_rdata  = i_m_rdata;
  assign o_l_rvalid = r_l_rvalid;
  assign o_l_rdata  = r_l_rdata;
  assign o_m_we     = (w_l_gnt & i_l_we) | (w_c_gnt & i_c_we);
  assign o_m_addr   = w_l_gnt ? i_l_addr  : i_c_addr;
  assign o_m_wdata  = w_l_gnt ? i_l_wdata : i_c_wdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: stimulus pushes expected read data into
// queues, a negedge monitor pops them as the DUT presents read results.
module tb_dmem_port_arbiter;
  localparam int AW = 32, DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          c_req, c_we, l_req, l_we, l_lock;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic [DW-1:0] c_rdata, l_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic          c_gnt, c_stall, l_gnt, l_rvalid, m_we;

  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] exp_l [$];
  logic [DW-1:0] exp_c [$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(4), .MAX_LOCK(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_c_req(c_req), .i_c_we(c_we), .i_c_addr(c_addr), .i_c_wdata(c_wdata),
    .o_c_rdata(c_rdata), .o_c_gnt(c_gnt), .o_c_stall(c_stall),
    .i_l_req(l_req), .i_l_we(l_we), .i_l_lock(l_lock), .i_l_addr(l_addr),
    .i_l_wdata(l_wdata), .o_l_gnt(l_gnt), .o_l_rvalid(l_rvalid), .o_l_rdata(l_rdata),
    .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .i_m_rdata(m_rdata)
  );

  assign m_rdata = mem[m_addr[7:2]];
  always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic grants(input string name, input logic cg, input logic lg, input logic st);
    @(negedge clk);
    chk({name, " c_gnt"}, 32'(c_gnt), 32'(cg));
    chk({name, " l_gnt"}, 32'(l_gnt), 32'(lg));
    chk({name, " c_stall"}, 32'(c_stall), 32'(st));
  endtask

  // Monitor: every loader read result and tracked core load is scored here.
  always @(negedge clk) begin
    if (l_rvalid) begin
      if (exp_l.size() == 0) chk("l_rvalid unexpected", 32'(l_rvalid), 32'd0);
      else chk("l_rdata", l_rdata, exp_l.pop_front());
    end
    if (c_gnt && !c_we && exp_c.size() != 0) chk("c_rdata", c_rdata, exp_c.pop_front());
  end

  task automatic loader_read(input logic [AW-1:0] a, input logic [DW-1:0] e);
    l_req = 1; l_we = 0; l_lock = 0; l_addr = a;
    exp_l.push_back(e);
    grants("lrd", 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic idle();
    c_req = 0; c_we = 0; l_req = 0; l_we = 0; l_lock = 0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    rst = 1; c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'h1111_1111;
    l_req = 1; l_we = 1; l_lock = 1; l_addr = 32'h14; l_wdata = 32'h2222_2222;
    #1;
    // Reset with both requesters writing: nothing granted or written.
    for (int k = 0; k < 2; k++) begin
      grants("reset", 1'b0, 1'b0, 1'b0);
      chk("reset m_we", 32'(m_we), 32'd0);
      if (k == 1) chk("reset l_rvalid", 32'(l_rvalid), 32'd0);
      tick();
    end
    chk("reset no write", mem[4], 32'd0);
    rst = 0; c_we = 0; l_we = 0; l_lock = 0;
    grants("post-reset", 1'b1, 1'b0, 1'b0);
    tick();
    idle();

    // Solo core store then load.
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEAD_BEEF;
    grants("core st", 1'b1, 1'b0, 1'b0);
    chk("core st m_we", 32'(m_we), 32'd1);
    tick();
    c_we = 0; exp_c.push_back(32'hDEAD_BEEF);
    grants("core ld", 1'b1, 1'b0, 1'b0);
    tick();

    // Starvation: loader wins on cycle 5, data arrives on cycle 6.
    c_req = 1; c_we = 0; c_addr = 32'h100;
    l_req = 1; l_we = 0; l_addr = 32'h10; exp_l.push_back(32'hDEAD_BEEF);
    for (int k = 1; k <= 4; k++) begin grants("starve core", 1'b1, 1'b0, 1'b0); tick(); end
    grants("starve ldr", 1'b0, 1'b1, 1'b1);
    tick();
    l_req = 0;
    grants("starve regrant", 1'b1, 1'b0, 1'b0);
    chk("starve l_rvalid", 32'(l_rvalid), 32'd1);
    tick();
    idle();

    // Burst lock: 8 locked beats, one yield, then loader resumes.
    c_req = 1; c_we = 0; c_addr = 32'h100;
    l_req = 1; l_we = 1; l_lock = 1; l_addr = 32'h0; l_wdata = 32'hA000_0000;
    for (int k = 1; k <= 4; k++) begin grants("burst pre", 1'b1, 1'b0, 1'b0); tick(); end
    for (int b = 0; b < 8; b++) begin
      l_addr = 32'(b * 4); l_wdata = 32'hA000_0000 | 32'(b);
      grants("burst beat", 1'b0, 1'b1, 1'b1);
      tick();
    end
    l_addr = 32'h20; l_wdata = 32'hA000_0008; l_lock = 0;
    grants("burst yield", 1'b1, 1'b0, 1'b0);
    chk("burst yield lock_cnt", 32'(dut.r_lock), 32'd8);
    tick();
    grants("burst resume", 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    for (int b = 0; b < 9; b++) loader_read(32'(b * 4), 32'hA000_0000 | 32'(b));
    idle();

    // Lock release on beat 3 returns the port to the core next cycle.
    c_req = 1; c_we = 0; c_addr = 32'h100;
    l_req = 1; l_we = 1; l_lock = 1; l_addr = 32'h30; l_wdata = 32'hB000_0001;
    for (int k = 1; k <= 4; k++) begin grants("rel pre", 1'b1, 1'b0, 1'b0); tick(); end
    grants("rel beat1", 1'b0, 1'b1, 1'b1); tick();
    l_addr = 32'h34; l_wdata = 32'hB000_0002;
    grants("rel beat2", 1'b0, 1'b1, 1'b1); tick();
    l_addr = 32'h38; l_wdata = 32'hB000_0003; l_lock = 0;
    grants("rel beat3", 1'b0, 1'b1, 1'b1); tick();
    l_req = 0;
    grants("rel core", 1'b1, 1'b0, 1'b0);
    chk("rel fsm", 32'(dut.r_state), 32'd0);
    chk("rel lock_cnt", 32'(dut.r_lock), 32'd0);
    tick();
    idle();

    // Reset during beat 4 of a locked burst.
    c_req = 1; c_we = 0; c_addr = 32'h100;
    l_req = 1; l_we = 1; l_lock = 1;
    for (int k = 1; k <= 4; k++) begin grants("rstb pre", 1'b1, 1'b0, 1'b0); tick(); end
    for (int b = 0; b < 3; b++) begin
      l_addr = 32'h50 + 32'(b * 4); l_wdata = 32'hC000_0000 | 32'(b);
      grants("rstb beat", 1'b0, 1'b1, 1'b1); tick();
    end
    l_addr = 32'h5C; l_wdata = 32'hC000_0003; rst = 1;
    grants("rstb rst", 1'b0, 1'b0, 1'b0);
    chk("rstb m_we", 32'(m_we), 32'd0);
    tick();
    rst = 0; c_req = 0; l_req = 0; l_lock = 0;
    @(negedge clk);
    chk("rstb fsm", 32'(dut.r_state), 32'd0);
    chk("rstb starve", 32'(dut.r_starve), 32'd0);
    chk("rstb lock", 32'(dut.r_lock), 32'd0);
    tick();
    loader_read(32'h58, 32'hC000_0002);
    loader_read(32'h5C, 32'h0);
    loader_read(32'h38, 32'hB000_0003);
    idle();
    idle();

    chk("exp_l drained", 32'(exp_l.size()), 32'd0);
    chk("exp_c drained", 32'(exp_c.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end
endmodule
